// File: rtl/priv_trap_ctrl_pkg.sv
// Shared types for the machine-mode trap controller: cause codes, exception flag bundle and the
// priority selector result.
package priv_trap_ctrl_pkg;

  typedef enum logic [3:0] {
    ExInsnMisaligned  = 4'd0,
    ExInsnFault       = 4'd1,
    ExIllegal         = 4'd2,
    ExBreakpoint      = 4'd3,
    ExLoadMisaligned  = 4'd4,
    ExLoadFault       = 4'd5,
    ExStoreMisaligned = 4'd6,
    ExStoreFault      = 4'd7,
    ExEcallM          = 4'd11
  } ex_code_t;

  typedef enum logic [3:0] {
    IntSoft  = 4'd3,
    IntTimer = 4'd7,
    IntExt   = 4'd11
  } int_code_t;

  typedef struct packed {
    logic breakpoint;
    logic fault_insn;
    logic mal_insn;
    logic illegal_insn;
    logic env_m;
    logic mal_l;
    logic mal_s;
    logic fault_l;
    logic fault_s;
  } exc_flags_t;

  typedef struct packed {
    logic       valid;
    logic       is_int;
    logic [3:0] code;
  } trap_sel_t;

  // Address-related exceptions report the faulting address in mtval.
  function automatic logic code_uses_badaddr(logic [3:0] code);
    return (code <= 4'd1) || ((code >= 4'd4) && (code <= 4'd7));
  endfunction

endpackage

// File: rtl/priv_trap_ctrl_if.sv
// Hazard/CSR/fetch-facing signal bundle of the trap controller. The slave modport is the
// controller; master is the surrounding pipeline.
interface priv_trap_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s;
  logic            breakpoint, env_m, ret;
  logic [XLEN-1:0] epc, badaddr;
  logic            timer_int, soft_int, ext_int, mie_global;
  logic [2:0]      mie_bits;
  logic [XLEN-1:0] mtvec, mepc_r;
  logic            pipe_clear;
  logic            intr, insert_pc, trap_we, ret_we;
  logic [XLEN-1:0] priv_pc, mepc_wdata, mcause_wdata, mtval_wdata;

  modport slave (
    input  fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env_m,
    input  ret, epc, badaddr, timer_int, soft_int, ext_int, mie_global, mie_bits, mtvec, mepc_r,
    input  pipe_clear,
    output intr, insert_pc, trap_we, ret_we, priv_pc, mepc_wdata, mcause_wdata, mtval_wdata
  );

  modport master (
    output fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env_m,
    output ret, epc, badaddr, timer_int, soft_int, ext_int, mie_global, mie_bits, mtvec, mepc_r,
    output pipe_clear,
    input  intr, insert_pc, trap_we, ret_we, priv_pc, mepc_wdata, mcause_wdata, mtval_wdata
  );
endinterface

// File: rtl/priv_trap_prio.sv
// Fixed-priority trap selector: any exception beats any enabled interrupt.
module priv_trap_prio
  import priv_trap_ctrl_pkg::*;
(
  input  exc_flags_t exc_i,
  input  logic [2:0] irq_i,        // {ext, timer, soft}
  input  logic       mie_global_i,
  input  logic [2:0] mie_bits_i,   // {MEIE, MTIE, MSIE}
  output trap_sel_t  sel_o
);

  logic [2:0] irq_en;
  assign irq_en = irq_i & mie_bits_i & {3{mie_global_i}};

  always_comb begin
    sel_o        = '0;
    sel_o.valid  = 1'b1;
    if (exc_i.breakpoint)        sel_o.code = ExBreakpoint;
    else if (exc_i.fault_insn)   sel_o.code = ExInsnFault;
    else if (exc_i.mal_insn)     sel_o.code = ExInsnMisaligned;
    else if (exc_i.illegal_insn) sel_o.code = ExIllegal;
    else if (exc_i.env_m)        sel_o.code = ExEcallM;
    else if (exc_i.mal_l)        sel_o.code = ExLoadMisaligned;
    else if (exc_i.mal_s)        sel_o.code = ExStoreMisaligned;
    else if (exc_i.fault_l)      sel_o.code = ExLoadFault;
    else if (exc_i.fault_s)      sel_o.code = ExStoreFault;
    else if (irq_en[2]) begin
      sel_o.is_int = 1'b1;
      sel_o.code   = IntExt;
    end else if (irq_en[0]) begin
      sel_o.is_int = 1'b1;
      sel_o.code   = IntSoft;
    end else if (irq_en[1]) begin
      sel_o.is_int = 1'b1;
      sel_o.code   = IntTimer;
    end else begin
      sel_o.valid  = 1'b0;
    end
  end

endmodule

// File: rtl/priv_trap_ctrl.sv
// Machine-mode trap/mret controller: latches the winning trap, runs the intr/pipe_clear flush
// handshake, then issues one commit cycle with CSR write strobes and a PC redirect.
module priv_trap_ctrl
  import priv_trap_ctrl_pkg::*;
#(
  parameter bit          VECTOR_EN = 1'b1,
  parameter int unsigned XLEN      = 32
) (
  input logic             clk,
  input logic             rst,
  priv_trap_ctrl_if.slave bus
);

  typedef logic [XLEN-1:0] word_t;
  typedef enum logic [1:0] {StIdle, StFlush, StCommit} trap_state_t;

  trap_state_t state_q;
  logic        is_ret_q, is_int_q;
  logic [3:0]  code_q;
  word_t       epc_q, mtval_q;
  logic        intr_q, insert_pc_q, trap_we_q, ret_we_q;
  word_t       priv_pc_q, mepc_wdata_q, mcause_wdata_q, mtval_wdata_q;

  exc_flags_t  exc;
  trap_sel_t   sel;
  word_t       sel_mtval, trap_target;

  assign exc = '{breakpoint: bus.breakpoint, fault_insn: bus.fault_insn, mal_insn: bus.mal_insn,
                 illegal_insn: bus.illegal_insn, env_m: bus.env_m, mal_l: bus.mal_l,
                 mal_s: bus.mal_s, fault_l: bus.fault_l, fault_s: bus.fault_s};

  priv_trap_prio u_prio (
    .exc_i        (exc),
    .irq_i        ({bus.ext_int, bus.timer_int, bus.soft_int}),
    .mie_global_i (bus.mie_global),
    .mie_bits_i   (bus.mie_bits),
    .sel_o        (sel)
  );

  always_comb begin
    sel_mtval = '0;
    if (!sel.is_int) begin
      if (sel.code == 4'(ExBreakpoint))   sel_mtval = bus.epc;
      else if (code_uses_badaddr(sel.code)) sel_mtval = bus.badaddr;
    end
  end

  // MODE 2/3 fall back to direct; only interrupts are vectored.
  always_comb begin
    trap_target = bus.mtvec & ~word_t'(3);
    if (VECTOR_EN && (bus.mtvec[1:0] == 2'b01) && is_int_q) begin
      trap_target = trap_target + word_t'({code_q, 2'b00});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      is_ret_q       <= 1'b0;
      is_int_q       <= 1'b0;
      code_q         <= '0;
      epc_q          <= '0;
      mtval_q        <= '0;
      intr_q         <= 1'b0;
      insert_pc_q    <= 1'b0;
      trap_we_q      <= 1'b0;
      ret_we_q       <= 1'b0;
      priv_pc_q      <= '0;
      mepc_wdata_q   <= '0;
      mcause_wdata_q <= '0;
      mtval_wdata_q  <= '0;
    end else begin
      insert_pc_q    <= 1'b0;
      trap_we_q      <= 1'b0;
      ret_we_q       <= 1'b0;
      priv_pc_q      <= '0;
      mepc_wdata_q   <= '0;
      mcause_wdata_q <= '0;
      mtval_wdata_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (sel.valid) begin
            is_ret_q <= 1'b0;
            is_int_q <= sel.is_int;
            code_q   <= sel.code;
            epc_q    <= bus.epc;
            mtval_q  <= sel_mtval;
            intr_q   <= 1'b1;
            state_q  <= StFlush;
          end else if (bus.ret) begin
            is_ret_q <= 1'b1;
            intr_q   <= 1'b1;
            state_q  <= StFlush;
          end
        end
        StFlush: begin
          if (bus.pipe_clear) begin
            intr_q      <= 1'b0;
            insert_pc_q <= 1'b1;
            state_q     <= StCommit;
            if (is_ret_q) begin
              ret_we_q  <= 1'b1;
              priv_pc_q <= bus.mepc_r & ~word_t'(3);
            end else begin
              trap_we_q      <= 1'b1;
              priv_pc_q      <= trap_target;
              mepc_wdata_q   <= epc_q;
              mcause_wdata_q <= {is_int_q, {(XLEN-5){1'b0}}, code_q};
              mtval_wdata_q  <= mtval_q;
            end
          end
        end
        StCommit: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign bus.intr         = intr_q;
  assign bus.insert_pc    = insert_pc_q;
  assign bus.trap_we      = trap_we_q;
  assign bus.ret_we       = ret_we_q;
  assign bus.priv_pc      = priv_pc_q;
  assign bus.mepc_wdata   = mepc_wdata_q;
  assign bus.mcause_wdata = mcause_wdata_q;
  assign bus.mtval_wdata  = mtval_wdata_q;

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Self-checking bench for priv_trap_ctrl: expected commits are queued when an event is driven
// and compared by a monitor when the redirect strobe appears.
module tb_priv_trap_ctrl;

  typedef struct {
    logic        is_ret;
    logic [31:0] pc;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  priv_trap_ctrl_if #(.XLEN(32)) bus ();

  priv_trap_ctrl #(.VECTOR_EN(1'b1), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    if (!rst && (bus.insert_pc || bus.trap_we || bus.ret_we)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit insert_pc=%b trap_we=%b ret_we=%b pc=%h want none",
                 bus.insert_pc, bus.trap_we, bus.ret_we, bus.priv_pc);
      end else begin
        mon_e = sb.pop_front();
        if ({bus.insert_pc, bus.trap_we, bus.ret_we, bus.priv_pc} !==
            {1'b1, !mon_e.is_ret, mon_e.is_ret, mon_e.pc}) begin
          errors++;
          $display("FAIL commit_strobes got ip=%b twe=%b rwe=%b pc=%h want ip=1 twe=%b rwe=%b pc=%h",
                   bus.insert_pc, bus.trap_we, bus.ret_we, bus.priv_pc,
                   !mon_e.is_ret, mon_e.is_ret, mon_e.pc);
        end
        if (!mon_e.is_ret) begin
          checks++;
          if ({bus.mepc_wdata, bus.mcause_wdata, bus.mtval_wdata} !==
              {mon_e.mepc, mon_e.mcause, mon_e.mtval}) begin
            errors++;
            $display("FAIL csr_wdata got mepc=%h mcause=%h mtval=%h want mepc=%h mcause=%h mtval=%h",
                     bus.mepc_wdata, bus.mcause_wdata, bus.mtval_wdata,
                     mon_e.mepc, mon_e.mcause, mon_e.mtval);
          end
        end
      end
    end
  end

  // f[0] = breakpoint (highest) ... f[8] = fault_s (lowest)
  task automatic set_flags(input logic [8:0] f);
    bus.breakpoint   = f[0];
    bus.fault_insn   = f[1];
    bus.mal_insn     = f[2];
    bus.illegal_insn = f[3];
    bus.env_m        = f[4];
    bus.mal_l        = f[5];
    bus.mal_s        = f[6];
    bus.fault_l      = f[7];
    bus.fault_s      = f[8];
  endtask

  // Drop all event inputs and scribble epc/badaddr to prove the latched copies are used.
  task automatic clear_events();
    set_flags(9'h000);
    bus.ret       = 1'b0;
    bus.timer_int = 1'b0;
    bus.soft_int  = 1'b0;
    bus.ext_int   = 1'b0;
    bus.epc       = 32'hDEAD_BEEF;
    bus.badaddr   = 32'hBAAD_F00D;
  endtask

  task automatic push_trap(input logic [31:0] pc, mepc, mcause, mtval);
    exp_t e;
    e = '{is_ret: 1'b0, pc: pc, mepc: mepc, mcause: mcause, mtval: mtval};
    sb.push_back(e);
  endtask

  // Caller has driven an event just after a clock edge.
  task automatic fire_and_commit(input int gap);
    @(posedge clk); #1;
    clear_events();
    checks++;
    if (bus.intr !== 1'b1) begin
      errors++;
      $display("FAIL intr_assert got %b want 1", bus.intr);
    end
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.intr !== 1'b1 || bus.insert_pc !== 1'b0) begin
        errors++;
        $display("FAIL flush_hold got intr=%b insert_pc=%b want 1 0", bus.intr, bus.insert_pc);
      end
    end
    bus.pipe_clear = 1'b1;
    @(posedge clk); #1;
    bus.pipe_clear = 1'b0;
    checks++;
    if (bus.insert_pc !== 1'b1 || bus.intr !== 1'b0) begin
      errors++;
      $display("FAIL commit_cycle got insert_pc=%b intr=%b want 1 0", bus.insert_pc, bus.intr);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.insert_pc, bus.trap_we, bus.ret_we, bus.intr} !== 4'b0000) begin
      errors++;
      $display("FAIL strobe_width got ip/twe/rwe/intr=%b want 0000",
               {bus.insert_pc, bus.trap_we, bus.ret_we, bus.intr});
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.intr, bus.insert_pc, bus.trap_we, bus.ret_we} !== 4'b0000 ||
        {bus.priv_pc, bus.mepc_wdata, bus.mcause_wdata, bus.mtval_wdata} !== 128'd0) begin
      errors++;
      $display("FAIL reset_state got strobes=%b pc=%h want 0 0",
               {bus.intr, bus.insert_pc, bus.trap_we, bus.ret_we}, bus.priv_pc);
    end
  endtask

  task automatic test_illegal();
    bus.mtvec        = 32'h8000_0000;
    bus.epc          = 32'h0000_0100;
    bus.badaddr      = 32'h1234_5678;
    bus.illegal_insn = 1'b1;
    push_trap(32'h8000_0000, 32'h0000_0100, 32'd2, 32'd0);
    fire_and_commit(2);
  endtask

  task automatic test_exc_beats_int();
    bus.mtvec      = 32'h8000_0000;
    bus.mie_global = 1'b1;
    bus.mie_bits   = 3'b111;
    bus.epc        = 32'h0000_0300;
    bus.badaddr    = 32'h0000_0203;
    bus.mal_l      = 1'b1;
    bus.fault_s    = 1'b1;
    bus.ext_int    = 1'b1;
    push_trap(32'h8000_0000, 32'h0000_0300, 32'd4, 32'h0000_0203);
    fire_and_commit(1);
  endtask

  task automatic test_exc_priority();
    int          codes[9] = '{3, 1, 0, 2, 11, 4, 6, 5, 7};
    logic [8:0]  f;
    logic [31:0] mtval;
    bus.mtvec = 32'h0000_2001; // vectored mode must not affect exceptions
    for (int i = 0; i < 9; i++) begin
      f           = 9'h1FF << i;
      bus.epc     = 32'h0000_1000 + 32'(i * 16);
      bus.badaddr = 32'h0000_9000 + 32'(i);
      if (codes[i] == 3) mtval = bus.epc;
      else if (codes[i] == 2 || codes[i] == 11) mtval = 32'd0;
      else mtval = bus.badaddr;
      set_flags(f);
      push_trap(32'h0000_2000, bus.epc, 32'(codes[i]), mtval);
      fire_and_commit(i % 3);
    end
  endtask

  task automatic test_vectored_timer();
    bus.mtvec      = 32'h8000_0001;
    bus.mie_global = 1'b1;
    bus.mie_bits   = 3'b010;
    bus.epc        = 32'h0000_0400;
    bus.timer_int  = 1'b1;
    push_trap(32'h8000_001C, 32'h0000_0400, 32'h8000_0007, 32'd0);
    fire_and_commit(0);
  endtask

  task automatic test_mret();
    exp_t e;
    bus.mepc_r = 32'h0000_0446;
    bus.ret    = 1'b1;
    e = '{is_ret: 1'b1, pc: 32'h0000_0444, mepc: 32'd0, mcause: 32'd0, mtval: 32'd0};
    sb.push_back(e);
    fire_and_commit(1);
  endtask

  task automatic test_masked_int();
    bus.mtvec      = 32'h8000_0001;
    bus.mie_global = 1'b0;
    bus.mie_bits   = 3'b001;
    bus.soft_int   = 1'b1;
    bus.epc        = 32'h0000_0500;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.intr !== 1'b0) begin
        errors++;
        $display("FAIL masked_int cycle %0d got intr=%b want 0", i, bus.intr);
      end
    end
    bus.mie_global = 1'b1;
    push_trap(32'h8000_000C, 32'h0000_0500, 32'h8000_0003, 32'd0);
    fire_and_commit(1);
  endtask

  task automatic test_rst_in_flush();
    bus.illegal_insn = 1'b1;
    bus.epc          = 32'h0000_0700;
    @(posedge clk); #1;
    clear_events();
    checks++;
    if (bus.intr !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_intr got %b want 1", bus.intr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.intr !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_intr got %b want 0", bus.intr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.pipe_clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.intr, bus.insert_pc, bus.trap_we, bus.ret_we} !== 4'b0000) begin
        errors++;
        $display("FAIL rst_idle_pipe_clear got strobes=%b want 0000",
                 {bus.intr, bus.insert_pc, bus.trap_we, bus.ret_we});
      end
    end
    bus.pipe_clear = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.mtvec      = 32'h0000_4000;
    bus.breakpoint = 1'b1;
    bus.epc        = 32'h0000_0500;
    bus.badaddr    = 32'h0000_0abc;
    push_trap(32'h0000_4000, 32'h0000_0500, 32'd3, 32'h0000_0500);
    fire_and_commit(0);
    bus.fault_insn = 1'b1;
    bus.epc        = 32'h0000_0600;
    bus.badaddr    = 32'h0000_0604;
    push_trap(32'h0000_4000, 32'h0000_0600, 32'd1, 32'h0000_0604);
    fire_and_commit(0);
  endtask

  initial begin
    clear_events();
    bus.epc        = '0;
    bus.badaddr    = '0;
    bus.mie_global = 1'b0;
    bus.mie_bits   = 3'b000;
    bus.mtvec      = '0;
    bus.mepc_r     = '0;
    bus.pipe_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_illegal();
    test_exc_beats_int();
    test_exc_priority();
    test_vectored_timer();
    test_mret();
    test_masked_int();
    test_rst_in_flush();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
